// File: rtl/multi_saturate_and_scale.sv
// Multi-lane saturate-and-scale: wide signed samples -> offset-binary symmetric codes
// with convergent rounding, plus windowed GT/LT counts and |x| sum for the AGC loop.
module multi_saturate_and_scale #(
  parameter int NSAMP     = 8,
  parameter int IN_WIDTH  = 48,
  parameter int LSB       = 4,
  parameter int OUT_BITS  = 5,
  parameter int CNT_WIDTH = 24,
  parameter int WIN_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NSAMP*IN_WIDTH-1:0] in_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [WIN_WIDTH-1:0]      window_len_i,
  output logic [NSAMP*OUT_BITS-1:0] out_o,
  output logic [NSAMP*(OUT_BITS-1)-1:0] abs_o,
  output logic [NSAMP-1:0]          gt_o,
  output logic [NSAMP-1:0]          lt_o,
  output logic [CNT_WIDTH-1:0]      gt_count_o,
  output logic [CNT_WIDTH-1:0]      lt_count_o,
  output logic [CNT_WIDTH-1:0]      abs_sum_o,
  output logic                      ovf_o,
  output logic                      done_o
);

  localparam int CW     = OUT_BITS - 1;
  localparam int TOP_LO = LSB + OUT_BITS - 1;
  localparam int UW     = IN_WIDTH - TOP_LO;
  localparam int PW     = $clog2(NSAMP + 1);
  localparam int SW     = CW + $clog2(NSAMP);

  logic [NSAMP*OUT_BITS-1:0] out_c;
  logic [NSAMP*CW-1:0]       abs_c;
  logic [NSAMP-1:0]          gt_c;
  logic [NSAMP-1:0]          lt_c;

  // Per-lane conversion. Out-of-range samples clamp to the extreme code of their sign.
  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    logic [IN_WIDTH-1:0] smp;
    logic                s;
    logic [OUT_BITS-1:0] base;
    logic [UW-1:0]       upper;
    logic                inb;
    logic [CW-1:0]       code;
    logic                unused_low;

    assign smp        = in_i[k*IN_WIDTH +: IN_WIDTH];
    assign unused_low = ^smp;
    assign s          = smp[IN_WIDTH-1];
    assign base       = smp[LSB +: OUT_BITS];
    assign upper      = smp[IN_WIDTH-1:TOP_LO];
    assign inb        = (&upper) | ~(|upper);
    assign code       = inb ? {base[CW-1:1], base[0] | smp[LSB-1]} : {CW{~s}};

    assign out_c[k*OUT_BITS +: OUT_BITS] = {~s, code};
    assign abs_c[k*CW +: CW]             = s ? ~code : code;
    assign gt_c[k] = inb ? (~s & base[CW-1]) : ~s;
    assign lt_c[k] = inb ? (s & ~base[CW-1]) : s;
  end

  // enable_i qualifies the samples of the same clock for statistics only; it travels
  // alongside the data through two pipeline registers and clear_i squashes it in flight.
  logic en_d1, en_d2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_o <= '0;
      abs_o <= '0;
      gt_o  <= '0;
      lt_o  <= '0;
      en_d1 <= 1'b0;
    end else begin
      out_o <= out_c;
      abs_o <= abs_c;
      gt_o  <= gt_c;
      lt_o  <= lt_c;
      en_d1 <= enable_i & ~clear_i;
    end
  end

  logic [PW-1:0] gt_pop, lt_pop, gt_s2, lt_s2;
  logic [SW-1:0] abs_tot, abs_s2;

  always_comb begin
    gt_pop  = '0;
    lt_pop  = '0;
    abs_tot = '0;
    for (int k = 0; k < NSAMP; k++) begin
      gt_pop  = gt_pop + PW'(gt_o[k]);
      lt_pop  = lt_pop + PW'(lt_o[k]);
      abs_tot = abs_tot + SW'(abs_o[k*CW +: CW]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gt_s2  <= '0;
      lt_s2  <= '0;
      abs_s2 <= '0;
      en_d2  <= 1'b0;
    end else begin
      gt_s2  <= gt_pop;
      lt_s2  <= lt_pop;
      abs_s2 <= abs_tot;
      en_d2  <= en_d1 & ~clear_i;
    end
  end

  function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                 input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t[CNT_WIDTH]) t = {1'b1, {CNT_WIDTH{1'b1}}};
    return t;
  endfunction

  logic [CNT_WIDTH-1:0] gt_acc, lt_acc, abs_acc;
  logic [CNT_WIDTH-1:0] gt_nxt, lt_nxt, abs_nxt;
  logic                 gt_ovf, lt_ovf, abs_ovf, ovf_q, ovf_nxt;
  logic [WIN_WIDTH-1:0] wcnt, len_q, len_eff;
  logic                 last;

  assign {gt_ovf, gt_nxt}   = sat_add(gt_acc, CNT_WIDTH'(gt_s2));
  assign {lt_ovf, lt_nxt}   = sat_add(lt_acc, CNT_WIDTH'(lt_s2));
  assign {abs_ovf, abs_nxt} = sat_add(abs_acc, CNT_WIDTH'(abs_s2));
  assign ovf_nxt = ovf_q | gt_ovf | lt_ovf | abs_ovf;

  // The window length is sampled only on the first qualified clock of a window.
  always_comb begin
    len_eff = len_q;
    if (wcnt == '0) len_eff = (window_len_i == '0) ? WIN_WIDTH'(1) : window_len_i;
  end
  assign last = (wcnt == len_eff - WIN_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gt_acc     <= '0;
      lt_acc     <= '0;
      abs_acc    <= '0;
      ovf_q      <= 1'b0;
      wcnt       <= '0;
      len_q      <= '0;
      gt_count_o <= '0;
      lt_count_o <= '0;
      abs_sum_o  <= '0;
      ovf_o      <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clear_i) begin
        gt_acc  <= '0;
        lt_acc  <= '0;
        abs_acc <= '0;
        ovf_q   <= 1'b0;
        wcnt    <= '0;
      end else if (en_d2) begin
        if (wcnt == '0) len_q <= len_eff;
        if (last) begin
          gt_count_o <= gt_nxt;
          lt_count_o <= lt_nxt;
          abs_sum_o  <= abs_nxt;
          ovf_o      <= ovf_nxt;
          done_o     <= 1'b1;
          gt_acc     <= '0;
          lt_acc     <= '0;
          abs_acc    <= '0;
          ovf_q      <= 1'b0;
          wcnt       <= '0;
        end else begin
          gt_acc  <= gt_nxt;
          lt_acc  <= lt_nxt;
          abs_acc <= abs_nxt;
          ovf_q   <= ovf_nxt;
          wcnt    <= wcnt + WIN_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_saturate_and_scale.sv
// Directed bench for multi_saturate_and_scale: datapath and window results are
// pushed to expected queues at issue time and popped by an independent monitor.
module tb_multi_saturate_and_scale;

  localparam int NSAMP = 8, IN_WIDTH = 48, LSB = 4, OUT_BITS = 5, CW = 4;
  localparam int WIN_WIDTH = 16, NV = 11;

  logic                      clk, rst_n;
  logic [NSAMP*IN_WIDTH-1:0] in_v;
  logic                      enable, en8, clear;
  logic [WIN_WIDTH-1:0]      window_len;

  logic [NSAMP*OUT_BITS-1:0] out_o, out8;
  logic [NSAMP*CW-1:0]       abs_o, abs8;
  logic [NSAMP-1:0]          gt_o, lt_o, gt8, lt8;
  logic [23:0]               gt_count_o, lt_count_o, abs_sum_o;
  logic [7:0]                gt_cnt8, lt_cnt8, abs_sum8;
  logic                      ovf_o, done_o, ovf8, done8;

  multi_saturate_and_scale #(.NSAMP(NSAMP), .IN_WIDTH(IN_WIDTH), .LSB(LSB),
    .OUT_BITS(OUT_BITS), .CNT_WIDTH(24), .WIN_WIDTH(WIN_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .enable_i(enable), .clear_i(clear),
    .window_len_i(window_len), .out_o(out_o), .abs_o(abs_o), .gt_o(gt_o), .lt_o(lt_o),
    .gt_count_o(gt_count_o), .lt_count_o(lt_count_o), .abs_sum_o(abs_sum_o),
    .ovf_o(ovf_o), .done_o(done_o));

  multi_saturate_and_scale #(.NSAMP(NSAMP), .IN_WIDTH(IN_WIDTH), .LSB(LSB),
    .OUT_BITS(OUT_BITS), .CNT_WIDTH(8), .WIN_WIDTH(WIN_WIDTH)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .enable_i(en8), .clear_i(clear),
    .window_len_i(window_len), .out_o(out8), .abs_o(abs8), .gt_o(gt8), .lt_o(lt8),
    .gt_count_o(gt_cnt8), .lt_count_o(lt_cnt8), .abs_sum_o(abs_sum8),
    .ovf_o(ovf8), .done_o(done8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // hand-computed vector table (LSB=4, OUT_BITS=5)
  logic signed [IN_WIDTH-1:0] tv_in [NV];
  logic [4:0] tv_out [NV];
  logic [3:0] tv_abs [NV];
  logic       tv_gt  [NV];
  logic       tv_lt  [NV];

  initial begin
    tv_in[0]  = 48'sd80;     tv_out[0]  = 5'd21; tv_abs[0]  = 4'd5;  tv_gt[0]  = 0; tv_lt[0]  = 0;
    tv_in[1]  = 48'sd72;     tv_out[1]  = 5'd21; tv_abs[1]  = 4'd5;  tv_gt[1]  = 0; tv_lt[1]  = 0;
    tv_in[2]  = 48'sd88;     tv_out[2]  = 5'd21; tv_abs[2]  = 4'd5;  tv_gt[2]  = 0; tv_lt[2]  = 0;
    tv_in[3]  = -48'sd1;     tv_out[3]  = 5'd15; tv_abs[3]  = 4'd0;  tv_gt[3]  = 0; tv_lt[3]  = 0;
    tv_in[4]  = -48'sd200;   tv_out[4]  = 5'd3;  tv_abs[4]  = 4'd12; tv_gt[4]  = 0; tv_lt[4]  = 1;
    tv_in[5]  = 48'sd1000;   tv_out[5]  = 5'd31; tv_abs[5]  = 4'd15; tv_gt[5]  = 1; tv_lt[5]  = 0;
    tv_in[6]  = -48'sd1000;  tv_out[6]  = 5'd0;  tv_abs[6]  = 4'd15; tv_gt[6]  = 0; tv_lt[6]  = 1;
    tv_in[7]  = 48'sh4000_0000_0000;
                             tv_out[7]  = 5'd31; tv_abs[7]  = 4'd15; tv_gt[7]  = 1; tv_lt[7]  = 0;
    tv_in[8]  = 48'sd200;    tv_out[8]  = 5'd29; tv_abs[8]  = 4'd13; tv_gt[8]  = 1; tv_lt[8]  = 0;
    tv_in[9]  = 48'sd255;    tv_out[9]  = 5'd31; tv_abs[9]  = 4'd15; tv_gt[9]  = 1; tv_lt[9]  = 0;
    tv_in[10] = -48'sd256;   tv_out[10] = 5'd0;  tv_abs[10] = 4'd15; tv_gt[10] = 0; tv_lt[10] = 1;
  end

  // scoreboard
  logic [87:0] exp_q[$];
  logic [72:0] win_q[$];
  logic [24:0] win8_q[$];
  int          done_cyc_q[$];
  int          n_checks = 0, n_pass = 0;
  int          last_cyc = 0;
  logic        dp_valid_in = 1'b0, dp_valid_q;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] e);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, e);
  endtask

  task automatic fail_extra(input string name);
    n_checks++;
    $display("FAIL %s: got done pulse expected none", name);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) dp_valid_q <= 1'b0;
    else        dp_valid_q <= dp_valid_in;

  // monitor
  logic [87:0] m_e;
  logic [72:0] m_w;
  logic [24:0] m_w8;
  int          m_c;
  always @(negedge clk) begin
    if (dp_valid_q) begin
      if (exp_q.size() == 0) fail_extra("datapath_unexpected");
      else begin
        m_e = exp_q.pop_front();
        check("datapath", {out_o, abs_o, gt_o, lt_o}, m_e);
      end
    end
    if (done_o) begin
      if (win_q.size() == 0) fail_extra("window_unexpected");
      else begin
        m_w = win_q.pop_front();
        m_c = done_cyc_q.pop_front();
        check("window", {gt_count_o, lt_count_o, abs_sum_o, ovf_o}, m_w);
        check("done_timing", cyc, m_c);
      end
    end
    if (done8) begin
      if (win8_q.size() == 0) fail_extra("window8_unexpected");
      else begin
        m_w8 = win8_q.pop_front();
        check("window8", {gt_cnt8, lt_cnt8, abs_sum8, ovf8}, m_w8);
      end
    end
  end

  // driver tasks
  task automatic drive(input int b, input int st, input logic en, input logic e8, input logic clr);
    logic [NSAMP*OUT_BITS-1:0] eo;
    logic [NSAMP*CW-1:0]       ea;
    logic [NSAMP-1:0]          eg, el;
    int idx;
    @(posedge clk); #1;
    for (int k = 0; k < NSAMP; k++) begin
      idx = (b + st * k) % NV;
      in_v[k*IN_WIDTH +: IN_WIDTH] = tv_in[idx];
      eo[k*OUT_BITS +: OUT_BITS]   = tv_out[idx];
      ea[k*CW +: CW]               = tv_abs[idx];
      eg[k] = tv_gt[idx];
      el[k] = tv_lt[idx];
    end
    enable = en; en8 = e8; clear = clr; dp_valid_in = 1'b1;
    exp_q.push_back({eo, ea, eg, el});
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_v = '0; enable = 1'b0; en8 = 1'b0; clear = 1'b0; dp_valid_in = 1'b0;
    end
  endtask

  task automatic expect_win(input logic [23:0] g, input logic [23:0] l, input logic [23:0] a,
                            input logic o);
    win_q.push_back({g, l, a, o});
    done_cyc_q.push_back(last_cyc + 3);
  endtask

  task automatic check_reset();
    check("rst_out", out_o, 0);
    check("rst_abs", abs_o, 0);
    check("rst_gt_lt", {gt_o, lt_o}, 0);
    check("rst_counts", {gt_count_o, lt_count_o, abs_sum_o}, 0);
    check("rst_ovf_done", {ovf_o, done_o}, 0);
    check("rst_counts8", {gt_cnt8, lt_cnt8, abs_sum8, ovf8, done8}, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_v = '0; enable = 1'b0; en8 = 1'b0; clear = 1'b0; window_len = 16'd4;
    repeat (3) @(posedge clk);
    #1 check_reset();
    rst_n = 1'b1;
    idle(2);

    // datapath: every table entry on all lanes, then two mixed-lane patterns
    for (int i = 0; i < NV; i++) drive(i, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 1, 1'b0, 1'b0, 1'b0);
    drive(3, 4, 1'b0, 1'b0, 1'b0);
    idle(3);

    // basic window of 4, all +1000
    window_len = 16'd4;
    repeat (4) drive(5, 0, 1'b1, 1'b0, 1'b0);
    expect_win(24'd32, 24'd0, 24'd480, 1'b0);
    idle(6);

    // len 1: back-to-back done pulses on mixed lanes
    window_len = 16'd1;
    drive(0, 1, 1'b1, 1'b0, 1'b0); expect_win(24'd2, 24'd2, 24'd72, 1'b0);
    drive(0, 1, 1'b1, 1'b0, 1'b0); expect_win(24'd2, 24'd2, 24'd72, 1'b0);
    idle(6);

    // len 0 behaves as 1
    window_len = 16'd0;
    drive(4, 0, 1'b1, 1'b0, 1'b0); expect_win(24'd0, 24'd8, 24'd96, 1'b0);
    idle(6);

    // pause: unqualified samples in the middle do not count
    window_len = 16'd4;
    repeat (2) drive(5, 0, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(6, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(5, 0, 1'b1, 1'b0, 1'b0);
    expect_win(24'd32, 24'd0, 24'd480, 1'b0);
    idle(6);

    // clear mid-window discards the partial window and in-flight samples
    repeat (2) drive(6, 0, 1'b1, 1'b0, 1'b0);
    drive(6, 0, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1, 0, 1'b1, 1'b0, 1'b0);
    expect_win(24'd0, 24'd0, 24'd160, 1'b0);
    idle(6);

    // 8-bit accumulators saturate over a 40-clock window
    window_len = 16'd40;
    repeat (40) drive(5, 0, 1'b0, 1'b1, 1'b0);
    win8_q.push_back({8'd255, 8'd0, 8'd255, 1'b1});
    idle(6);

    // asynchronous reset mid-window
    window_len = 16'd4;
    repeat (2) drive(6, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // fresh window after reset excludes the pre-reset samples
    repeat (4) drive(8, 0, 1'b1, 1'b0, 1'b0);
    expect_win(24'd32, 24'd0, 24'd416, 1'b0);
    idle(8);

    check("dp_queue_drained", exp_q.size(), 0);
    check("win_queue_drained", win_q.size(), 0);
    check("win8_queue_drained", win8_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_saturate_and_scale.md
# multi_saturate_and_scale

Multi-lane, parametrised saturate-and-scale stage with built-in AGC statistics. It sits between the per-channel AGC DSP outputs and the beamformer/L1 storage. It converts NSAMP wide signed samples per clock into OUT_BITS offset-binary symmetric codes with convergent rounding. It also accumulates windowed GT/LT threshold counts and an |x| sum, which the AGC loop uses for gain and DC/symmetry correction. Unlike the single-sample generation, it detects saturation itself from the input MSBs, so no DSP pattern-detect inputs are needed.

## Interface
- NSAMP, 8, samples (lanes) per clock
- IN_WIDTH, 48, signed input sample width
- LSB, 4, input bit mapped to output LSB; must be >= 1 (one bit below is used for rounding)
- OUT_BITS, 5, output code width; >= 3; IN_WIDTH >= LSB+OUT_BITS+1
- CNT_WIDTH, 24, width of every window accumulator
- WIN_WIDTH, 16, width of window length
- clk_i  in  1  sample clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_i  in  NSAMP*IN_WIDTH  signed two's-complement samples, lane k at [k*IN_WIDTH +: IN_WIDTH]
- enable_i  in  1  qualify current clock's samples for statistics
- clear_i  in  1  synchronous: abort window, zero accumulators and window counter
- window_len_i  in  WIN_WIDTH  clocks (enabled) per statistics window; 0 treated as 1
- out_o  out  NSAMP*OUT_BITS  offset-binary scaled codes
- abs_o  out  NSAMP*(OUT_BITS-1)  symmetric magnitude per lane
- gt_o, lt_o  out  NSAMP each  per-lane threshold flags
- gt_count_o, lt_count_o, abs_sum_o  out  CNT_WIDTH each  last completed window results
- ovf_o  out  1  some accumulator saturated in last completed window
- done_o  out  1  one-cycle pulse when window results update

## Operation
- Per lane, s = sign bit in[IN_WIDTH-1], base = in[LSB +: OUT_BITS].
- in_bounds = bits [IN_WIDTH-1 : LSB+OUT_BITS-1] all equal.
- In bounds: code[OUT_BITS-2:1] = base[OUT_BITS-2:1]; code[0] = base[0] | in[LSB-1]. This is convergent rounding, with no carry.
- In bounds: gt = !s & base[OUT_BITS-2]; lt = s & !base[OUT_BITS-2].
- Out of bounds: code[OUT_BITS-2:0] = all !s; gt = !s; lt = s; abs = all ones.
- out MSB = !s always, i.e. offset binary.
- abs = s ? ~code[OUT_BITS-2:0] : code[OUT_BITS-2:0]. This is a symmetric representation, with no +1.
- Statistics path:
  - Stage 2 registers per-clock popcount(gt), popcount(lt), sum(abs), and enable delayed by 2.
  - Stage 3 adds them into accumulators when the delayed enable is high.
- Window counter wcnt counts delayed-enable clocks.
  - window_len is latched when wcnt == 0 and a qualified clock arrives.
  - On the qualified clock with wcnt == len-1, the result registers take acc + current stage-2 values, and ovf_o takes the ovf status.
  - On that same clock, done_o is registered high, the accumulators and wcnt go to 0, and the ovf status clears.
- Accumulators saturate at all-ones and set the internal ovf status; they never wrap.
- enable_i low pauses the window (wcnt and accumulators hold). The datapath outputs keep updating regardless.
- clear_i has priority over window completion. In the clear cycle, result registers and done_o are not updated. clear_i also flushes the stage-2 enable pipeline (the qualified samples in flight are discarded).
- window_len_i changes mid-window take effect at the next window start.

## Timing
- Reset values:
  - all outputs 0 (out_o = 0 is the most-negative code)
  - accumulators, wcnt, pipeline valids 0
- out_o, abs_o, gt_o, lt_o: latency 1 clock from in_i.
- A sample at edge n contributes to accumulators at edge n+3.
- If it closes a window, gt_count_o/lt_count_o/abs_sum_o/ovf_o update and done_o is high for the cycle after edge n+3.
- done_o is never high on two consecutive cycles unless len == 1 with continuous enable.
- Reset assertion mid-window discards everything asynchronously. After release, the first window starts fresh.

## Test plan
Parameters: NSAMP=8, LSB=4, OUT_BITS=5.
- Rounding: lane in = 80, 72, 88 -> out 21 (5'b10101) for all three, abs 5, gt 0, lt 0, one clock later.
- Negative near zero: in = -1 -> out 15, abs 0, gt 0, lt 0. in = -200 -> out 3, abs 12, lt 1.
- Saturation:
  - in = +1000 -> out 31, abs 15, gt 1.
  - in = -1000 -> out 0, abs 15, lt 1.
  - in = 2^46 (high bits only) -> out 31.
- Window: window_len 4, all lanes +1000, enable high for 4 clocks -> one done_o pulse 3 clocks after the last sample; gt_count 32, lt_count 0, abs_sum 480, ovf 0.
- Pause/clear:
  - enable low for 2 clocks mid-window -> same totals as the window test, with done_o delayed 2 clocks.
  - clear_i mid-window -> no done_o; next window totals exclude pre-clear samples.
- Overflow and reset: CNT_WIDTH=8, window_len 40, all +1000 -> abs_sum 255, ovf_o 1. Assert rst_ni mid-window -> all outputs 0 immediately.
